// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead subtractor.
package cla_pkg;

  localparam int unsigned NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/serial_cla_subtractor_if.sv
// Operand and result handshake bundle for serial_cla_subtractor.
interface serial_cla_subtractor_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
endinterface

// File: rtl/cla_sub4.sv
// 4-bit carry-lookahead subtract slice: d = a + ~b + cin.
module cla_sub4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] d,
  output logic       cout
);
  logic [3:0] bn;
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  always_comb begin
    bn   = ~b;
    g    = a & bn;
    p    = a ^ bn;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    d    = p ^ c;
  end
endmodule

// File: rtl/serial_cla_subtractor.sv
// WIDTH-bit a - b - bin computed one nibble per clock through a single
// lookahead slice; carry (inverted borrow) is registered between nibbles.
module serial_cla_subtractor
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_cla_subtractor_if.slave  bus
);
  localparam int unsigned NIBS   = WIDTH / NIBBLE;
  localparam int unsigned KW     = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam int unsigned MSB    = WIDTH - 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBS - 1);

  if ((WIDTH < NIBBLE) || ((WIDTH % NIBBLE) != 0)) begin : g_width_check
    $error("serial_cla_subtractor: WIDTH must be a multiple of 4 and >= 4");
  end

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, work_q, diff_q;
  logic             carry_q, bout_q, ovf_q;
  logic [KW-1:0]    k_q;

  logic             in_ready, out_valid, accept, last;
  logic [KW+1:0]    shamt;
  logic [3:0]       a_nib, b_nib, d_nib;
  logic             c_out;
  logic [WIDTH-1:0] work_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (k_q == K_LAST) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Nibble k is brought to bit 0 by shifting, then merged back in place.
  always_comb begin
    shamt  = {k_q, 2'b00};
    a_nib  = NIBBLE'(a_q >> shamt);
    b_nib  = NIBBLE'(b_q >> shamt);
    work_d = (work_q & ~(WIDTH'(4'hF) << shamt)) | (WIDTH'(d_nib) << shamt);
  end

  cla_sub4 u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .d    (d_nib),
    .cout (c_out)
  );

  // Results are published only on the final nibble so outputs hold during RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      diff_q  <= '0;
      carry_q <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      k_q     <= '0;
    end else if (accept) begin
      a_q     <= bus.a;
      b_q     <= bus.b;
      carry_q <= ~bus.bin;
      k_q     <= '0;
    end else if (state_q == RUN) begin
      work_q  <= work_d;
      carry_q <= c_out;
      if (last) begin
        diff_q <= work_d;
        bout_q <= ~c_out;
        ovf_q  <= (a_q[MSB] != b_q[MSB]) & (work_d[MSB] != a_q[MSB]);
      end else begin
        k_q <= k_q + KW'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_serial_cla_subtractor.sv
// Directed bench for serial_cla_subtractor (WIDTH=16).
module tb_serial_cla_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  serial_cla_subtractor_if #(.WIDTH(16)) bus ();

  serial_cla_subtractor #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Drives one operation and waits for out_valid; returns cycles after accept.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        output int lat);
    logic acc;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.bin = bin; bus.in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    lat = -1;
    if (acc) begin
      for (int i = 1; i <= 20; i++) begin
        if (bus.out_valid) break;
        @(posedge clk); #1;
        if (bus.out_valid) begin lat = i; break; end
      end
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.diff !== 16'h0 ||
        bus.bout !== 1'b0 || bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset: in_ready=%b out_valid=%b diff=%h bout=%b ovf=%b want 1 0 0000 0 0",
               bus.in_ready, bus.out_valid, bus.diff, bus.bout, bus.ovf);
    end
  endtask

  task automatic test_vectors();
    logic [15:0] va   [8] = '{16'h1234, 16'h1000, 16'h0000, 16'h0005, 16'h8000, 16'h7FFF, 16'hABCD, 16'hFFFF};
    logic [15:0] vb   [8] = '{16'h0234, 16'h0001, 16'h0001, 16'h0005, 16'h0001, 16'hFFFF, 16'h1234, 16'h0000};
    logic        vbin [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] ed   [8] = '{16'h1000, 16'h0FFF, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h9999, 16'hFFFE};
    logic        eb   [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        eo   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int lat;
    for (int i = 0; i < 8; i++) begin
      run_op(va[i], vb[i], vbin[i], lat);
      checks++;
      if (lat !== 4) begin
        failures++;
        $display("FAIL latency[%0d]: got %0d want 4", i, lat);
      end
      checks++;
      if (bus.diff !== ed[i] || bus.bout !== eb[i] || bus.ovf !== eo[i]) begin
        failures++;
        $display("FAIL result[%0d]: diff=%h bout=%b ovf=%b want diff=%h bout=%b ovf=%b",
                 i, bus.diff, bus.bout, bus.ovf, ed[i], eb[i], eo[i]);
      end
      release_result();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL handoff[%0d]: out_valid=%b in_ready=%b want 0 1", i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(16'h00FF, 16'h000F, 1'b0, lat);
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL bp_latency: got %0d want 4", lat);
    end
    @(negedge clk);
    bus.a = 16'hFFFF; bus.b = 16'h1111; bus.bin = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.diff !== 16'h00F0 ||
          bus.bout !== 1'b0 || bus.ovf !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b diff=%h bout=%b ovf=%b want 1 0 00f0 0 0",
                 i, bus.out_valid, bus.in_ready, bus.diff, bus.bout, bus.ovf);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.diff !== 16'h00F0) begin
      failures++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b diff=%h want 0 1 00f0",
               bus.out_valid, bus.in_ready, bus.diff);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bus.out_ready = 1'b1;
    run_op(16'h4000, 16'h4001, 1'b0, lat);
    checks++;
    if (lat !== 4 || bus.diff !== 16'hFFFF || bus.bout !== 1'b1 || bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first: lat=%0d diff=%h bout=%b ovf=%b want 4 ffff 1 0",
               lat, bus.diff, bus.bout, bus.ovf);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_return: out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    run_op(16'h0F0F, 16'h0101, 1'b1, lat);
    checks++;
    if (lat !== 4 || bus.diff !== 16'h0E0D || bus.bout !== 1'b0 || bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second: lat=%0d diff=%h bout=%b ovf=%b want 4 0e0d 0 0",
               lat, bus.diff, bus.bout, bus.ovf);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_in_run();
    int lat;
    @(negedge clk);
    bus.a = 16'h1234; bus.b = 16'h0234; bus.bin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_abort: out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.diff !== 16'h0 ||
        bus.bout !== 1'b0 || bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL rst_release: in_ready=%b out_valid=%b diff=%h bout=%b ovf=%b want 1 0 0000 0 0",
               bus.in_ready, bus.out_valid, bus.diff, bus.bout, bus.ovf);
    end
    run_op(16'h0010, 16'h0001, 1'b0, lat);
    checks++;
    if (lat !== 4 || bus.diff !== 16'h000F || bus.bout !== 1'b0 || bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL rst_next_op: lat=%0d diff=%h bout=%b ovf=%b want 4 000f 0 0",
               lat, bus.diff, bus.bout, bus.ovf);
    end
    release_result();
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_vectors();
    test_backpressure();
    test_back_to_back();
    test_reset_in_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
